// File: rtl/fighter_controller.sv
// rtl/fighter_controller.sv - per-player fighter game-logic FSM feeding the sprite renderer
module fighter_controller #(
    parameter int TICK_DIV    = 3_333_333,
    parameter int X_START     = 24,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 88,
    parameter int GROUND_Y    = 32,
    parameter int JUMP_V      = 6,
    parameter int PUNCH_TICKS = 8,
    parameter int SP_TICKS    = 12,
    parameter int INJ_TICKS   = 10,
    parameter int COMBO_WIN   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_attack,
    input  logic [6:0] opp_x,
    input  logic       hit,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic       in_air,
    output logic [1:0] move_state,
    output logic [2:0] character_state,
    output logic       mirror,
    output logic       strike
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = $clog2(COMBO_WIN + 1);

    typedef enum logic [2:0] {
        CH_NORMAL  = 3'b000,
        CH_PUNCH   = 3'b001,
        CH_SPECIAL = 3'b010,
        CH_INJURED = 3'b100
    } char_t;

    char_t            char_q, char_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       x_q, x_d, y_q, y_d;
    logic [4:0]       vy_q, vy_d;
    logic             in_air_q, in_air_d, mirror_q, mirror_d, strike_q, strike_d;
    logic [1:0]       move_q, move_d, stage_q, stage_d;
    logic [3:0]       timer_q, timer_d;
    logic             atk_pend_q, atk_pend_d, hit_pend_q, hit_pend_d;
    logic [3:0]       prev_q, prev_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic             tick, atk_edge, left_edge, down_edge, right_edge, atk_eff, hit_eff;
    logic [1:0]       stage_base;
    logic [6:0]       x_dec, x_inc;
    logic signed [7:0] y_next;

    // Next-state: edge/pending capture every clk, game state only on tick cycles
    always_comb begin
        tick       = (div_q == DIV_W'(TICK_DIV - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        prev_d     = {btn_attack, btn_left, btn_down, btn_right};
        atk_edge   = btn_attack & ~prev_q[3];
        left_edge  = btn_left   & ~prev_q[2];
        down_edge  = btn_down   & ~prev_q[1];
        right_edge = btn_right  & ~prev_q[0];
        atk_eff    = atk_pend_q | atk_edge;
        hit_eff    = hit_pend_q | hit;
        x_dec      = (x_q > 7'(X_MIN)) ? x_q - 7'd1 : x_q;
        x_inc      = (x_q < 7'(X_MAX)) ? x_q + 7'd1 : x_q;
        y_next     = $signed({1'b0, y_q}) - $signed({{3{vy_q[4]}}, vy_q});

        x_d        = x_q;
        y_d        = y_q;
        vy_d       = vy_q;
        in_air_d   = in_air_q;
        move_d     = move_q;
        char_d     = char_q;
        mirror_d   = mirror_q;
        strike_d   = 1'b0;
        timer_d    = timer_q;
        atk_pend_d = atk_eff;
        hit_pend_d = hit_eff;
        gap_d      = gap_q;
        stage_base = stage_q;

        // Combo window: once COMBO_WIN ticks have passed since the last press, the next tick drops the stage
        if (tick) begin
            if (gap_q >= GAP_W'(COMBO_WIN)) begin
                stage_base = 2'd0;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
        stage_d = stage_base;
        if (left_edge) begin
            stage_d = 2'd1;
            gap_d   = '0;
        end else if (down_edge) begin
            stage_d = (stage_base == 2'd1) ? 2'd2 : 2'd0;
            gap_d   = '0;
        end else if (right_edge) begin
            stage_d = (stage_base == 2'd2) ? 2'd3 : 2'd0;
            gap_d   = '0;
        end

        if (tick) begin
            if (opp_x < x_q) begin
                mirror_d = 1'b1;
            end else if (opp_x > x_q) begin
                mirror_d = 1'b0;
            end

            // Gravity runs regardless of character state
            if (in_air_q) begin
                if (y_next >= $signed(8'(GROUND_Y))) begin
                    y_d      = 7'(GROUND_Y);
                    vy_d     = 5'd0;
                    in_air_d = 1'b0;
                end else begin
                    y_d  = y_next[6:0];
                    vy_d = vy_q - 5'd1;
                end
            end

            move_d = 2'b00;
            if (hit_eff) begin
                char_d     = CH_INJURED;
                timer_d    = 4'(INJ_TICKS - 1);
                hit_pend_d = 1'b0;
                atk_pend_d = 1'b0;
                x_d        = (opp_x > x_q) ? x_dec : x_inc;
            end else if (char_q != CH_NORMAL) begin
                if (timer_q == 4'd0) begin
                    char_d = CH_NORMAL;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
                if (char_q == CH_INJURED) begin
                    atk_pend_d = 1'b0;
                    if (timer_q != 4'd0) begin
                        x_d = (opp_x > x_q) ? x_dec : x_inc;
                    end
                end
            end else if (atk_eff) begin
                atk_pend_d = 1'b0;
                if (!in_air_q) begin
                    strike_d = 1'b1;
                    if (stage_base == 2'd3) begin
                        char_d  = CH_SPECIAL;
                        timer_d = 4'(SP_TICKS - 1);
                        stage_d = 2'd0;
                    end else begin
                        char_d  = CH_PUNCH;
                        timer_d = 4'(PUNCH_TICKS - 1);
                    end
                end
            end else begin
                if (btn_right ^ btn_left) begin
                    move_d = (btn_right == !mirror_d) ? 2'b01 : 2'b10;
                    x_d    = btn_right ? x_inc : x_dec;
                end
                if (btn_up && !in_air_q) begin
                    y_d      = 7'(GROUND_Y - JUMP_V);
                    vy_d     = 5'(JUMP_V - 1);
                    in_air_d = 1'b1;
                end
            end
        end
    end

    // State register; buttons held through reset are sampled so they do not read as fresh presses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            x_q        <= 7'(X_START);
            y_q        <= 7'(GROUND_Y);
            vy_q       <= 5'd0;
            in_air_q   <= 1'b0;
            move_q     <= 2'b00;
            char_q     <= CH_NORMAL;
            mirror_q   <= 1'b0;
            strike_q   <= 1'b0;
            timer_q    <= 4'd0;
            atk_pend_q <= 1'b0;
            hit_pend_q <= 1'b0;
            stage_q    <= 2'd0;
            gap_q      <= '0;
            prev_q     <= prev_d;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            in_air_q   <= in_air_d;
            move_q     <= move_d;
            char_q     <= char_d;
            mirror_q   <= mirror_d;
            strike_q   <= strike_d;
            timer_q    <= timer_d;
            atk_pend_q <= atk_pend_d;
            hit_pend_q <= hit_pend_d;
            stage_q    <= stage_d;
            gap_q      <= gap_d;
            prev_q     <= prev_d;
        end
    end

    assign x               = x_q;
    assign y               = y_q;
    assign in_air          = in_air_q;
    assign move_state      = move_q;
    assign character_state = char_q;
    assign mirror          = mirror_q;
    assign strike          = strike_q;

endmodule

// File: tb/tb_fighter_controller.sv
// tb/tb_fighter_controller.sv - directed bench with behavioural model for fighter_controller
module tb_fighter_controller;

    localparam int TD = 4;
    localparam int X_START = 24, X_MIN = 8, X_MAX = 88, GROUND_Y = 32, JUMP_V = 6;
    localparam int PUNCH_T = 8, SP_T = 12, INJ_T = 10, COMBO_WIN = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_attack = 1'b0;
    logic [6:0] opp_x = 7'd100;
    logic       hit = 1'b0;
    logic [6:0] x, y;
    logic       in_air, mirror, strike;
    logic [1:0] move_state;
    logic [2:0] character_state;

    always #5 clk = ~clk;

    fighter_controller #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_attack(btn_attack),
        .opp_x(opp_x), .hit(hit),
        .x(x), .y(y), .in_air(in_air), .move_state(move_state),
        .character_state(character_state), .mirror(mirror), .strike(strike)
    );

    int n_total = 0, n_pass = 0, strike_total = 0;
    int m_x = X_START, m_y = GROUND_Y, m_air = 0, m_vy = 0, m_move = 0, m_char = 0;
    int m_mir = 0, m_strike = 0, m_div = 0, m_apend = 0, m_hpend = 0;
    int m_stage = 0, m_last = 0, m_tickno = 0, m_start = 0, m_dur = 0;
    bit p_a = 0, p_l = 0, p_d = 0, p_r = 0;
    int ys [13] = '{26, 21, 17, 14, 12, 11, 11, 12, 14, 17, 21, 26, 32};

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step_away();
        if (opp_x > m_x) m_x = (m_x > X_MIN) ? m_x - 1 : m_x;
        else             m_x = (m_x < X_MAX) ? m_x + 1 : m_x;
    endtask

    // Game rules applied once per clock, in ticks and press timestamps
    task automatic model_step();
        bit ae, le, de, re, tk, was_air, was_inj;
        int base;
        if (!rst_n) begin
            m_x = X_START; m_y = GROUND_Y; m_air = 0; m_vy = 0; m_move = 0; m_char = 0;
            m_mir = 0; m_strike = 0; m_div = 0; m_apend = 0; m_hpend = 0; m_stage = 0;
            m_last = m_tickno;
        end else begin
            ae = btn_attack && !p_a; le = btn_left && !p_l;
            de = btn_down && !p_d;   re = btn_right && !p_r;
            tk = (m_div == TD - 1);
            m_div = tk ? 0 : m_div + 1;
            if (tk) m_tickno++;
            base = (m_tickno - m_last > COMBO_WIN) ? 0 : m_stage;
            m_stage = base;
            if (le)      begin m_stage = 1; m_last = m_tickno; end
            else if (de) begin m_stage = (base == 1) ? 2 : 0; m_last = m_tickno; end
            else if (re) begin m_stage = (base == 2) ? 3 : 0; m_last = m_tickno; end
            if (ae) m_apend = 1;
            if (hit) m_hpend = 1;
            m_strike = 0;
            if (tk) begin
                was_air = (m_air != 0);
                was_inj = (m_char == 4);
                if (opp_x < m_x) m_mir = 1;
                else if (opp_x > m_x) m_mir = 0;
                if (was_air) begin
                    if (m_y - m_vy >= GROUND_Y) begin m_y = GROUND_Y; m_vy = 0; m_air = 0; end
                    else begin m_y = m_y - m_vy; m_vy = m_vy - 1; end
                end
                m_move = 0;
                if (m_hpend != 0) begin
                    m_char = 4; m_start = m_tickno; m_dur = INJ_T;
                    m_hpend = 0; m_apend = 0; step_away();
                end else if (m_char != 0) begin
                    if (m_tickno - m_start >= m_dur) m_char = 0;
                    else if (was_inj) step_away();
                    if (was_inj) m_apend = 0;
                end else if (m_apend != 0) begin
                    m_apend = 0;
                    if (!was_air) begin
                        if (m_stage == 3) begin m_char = 2; m_dur = SP_T; m_stage = 0; end
                        else begin m_char = 1; m_dur = PUNCH_T; end
                        m_start = m_tickno; m_strike = 1;
                    end
                end else begin
                    if (btn_right != btn_left) begin
                        m_move = ((btn_right == 1'b1) == (m_mir == 0)) ? 1 : 2;
                        if (btn_right) m_x = (m_x < X_MAX) ? m_x + 1 : X_MAX;
                        else           m_x = (m_x > X_MIN) ? m_x - 1 : X_MIN;
                    end
                    if (btn_up && !was_air) begin
                        m_y = GROUND_Y - JUMP_V; m_vy = JUMP_V - 1; m_air = 1;
                    end
                end
            end
        end
        p_a = btn_attack; p_l = btn_left; p_d = btn_down; p_r = btn_right;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cyc();
        int act, exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (strike === 1'b1) strike_total++;
        act = int'({x, y, in_air, move_state, character_state, mirror, strike});
        exp = (m_x << 15) | (m_y << 8) | (m_air << 7) | (m_move << 5) | (m_char << 2) | (m_mir << 1) | m_strike;
        chk("cycle_model", act, exp);
    endtask

    task automatic wait_tick();
        int t0, n;
        t0 = m_tickno; n = 0;
        while (m_tickno == t0 && n < 3 * TD) begin cyc(); n++; end
        if (m_tickno == t0) chk("tick_timeout", 0, 1);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: btn_left = v;
            1: btn_down = v;
            2: btn_right = v;
            3: btn_attack = v;
            default: btn_up = v;
        endcase
    endtask

    task automatic press(input int b, input int gap);
        set_btn(b, 1'b1);
        wait_tick();
        set_btn(b, 1'b0);
        repeat (gap - 1) wait_tick();
    endtask

    initial begin
        int cnt, cnt2, s0;
        // Reset with a direction held
        btn_right = 1'b1;
        repeat (3) cyc();
        chk("rst_x", x, 24); chk("rst_y", y, 32); chk("rst_in_air", in_air, 0);
        chk("rst_move", move_state, 0); chk("rst_char", character_state, 0);
        chk("rst_mirror", mirror, 0); chk("rst_strike", strike, 0);
        rst_n = 1'b1;
        cyc();
        chk("x_before_first_tick", x, 24);
        wait_tick();
        chk("x_first_tick", x, 25);
        btn_right = 1'b0;

        // Walk right into the clamp
        btn_right = 1'b1;
        repeat (61) wait_tick();
        chk("walk_to_86", x, 86);
        wait_tick(); chk("x_87", x, 87); chk("move_87", move_state, 1);
        wait_tick(); chk("x_88", x, 88); chk("move_88", move_state, 1);
        wait_tick(); chk("x_88_clamp", x, 88); chk("move_clamp", move_state, 1); chk("mirror_r", mirror, 0);
        btn_right = 1'b0;

        // Walk left into the lower clamp
        btn_left = 1'b1;
        repeat (81) wait_tick();
        chk("x_min_clamp", x, 8); chk("move_back_clamp", move_state, 2);
        btn_left = 1'b0;

        // Jump arc
        btn_up = 1'b1;
        wait_tick();
        btn_up = 1'b0;
        chk("jump_y0", y, ys[0]); chk("jump_air0", in_air, 1);
        for (int i = 1; i < 13; i++) begin
            wait_tick();
            chk("jump_y", y, ys[i]);
            chk("jump_air", in_air, (i == 12) ? 0 : 1);
        end

        // Grounded punch
        s0 = strike_total; cnt = 0;
        btn_attack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (i == 0) btn_attack = 1'b0;
            if (character_state == 3'b001) cnt++;
        end
        chk("punch_ticks", cnt, 8);
        chk("punch_strike_clks", strike_total - s0, 1);

        // Attack mid-jump is dropped
        press(4, 3);
        cnt = 0;
        btn_attack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (i == 0) btn_attack = 1'b0;
            if (character_state != 3'b000) cnt++;
        end
        chk("air_attack_ignored", cnt, 0);
        repeat (2) wait_tick();

        // Combo in time -> special
        press(0, 3); press(1, 3); press(2, 3);
        s0 = strike_total; cnt = 0;
        btn_attack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_tick();
            if (i == 0) btn_attack = 1'b0;
            if (character_state == 3'b010) cnt++;
        end
        chk("special_ticks", cnt, 12);
        chk("special_strike_clks", strike_total - s0, 1);

        // Combo with a stale gap -> plain punch
        press(0, 3); press(1, 20); press(2, 3);
        cnt = 0; cnt2 = 0;
        btn_attack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_tick();
            if (i == 0) btn_attack = 1'b0;
            if (character_state == 3'b001) cnt++;
            if (character_state == 3'b010) cnt2++;
        end
        chk("stale_combo_punch", cnt, 8);
        chk("stale_combo_no_special", cnt2, 0);

        // Hit during punch, opponent to the right
        btn_right = 1'b1;
        repeat (30) wait_tick();
        btn_right = 1'b0;
        chk("x_before_hit", x, 39);
        btn_attack = 1'b1;
        wait_tick();
        btn_attack = 1'b0;
        chk("punch_before_hit", character_state, 1);
        wait_tick();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            wait_tick();
            chk("injured_char", character_state, 4);
            chk("injured_x", x, 39 - k);
        end
        wait_tick();
        chk("injured_exit_char", character_state, 0);
        chk("injured_exit_x", x, 29);

        // Opponent to the left: facing flips, walking right is backward
        opp_x = 7'd0;
        btn_right = 1'b1;
        wait_tick();
        btn_right = 1'b0;
        chk("mirror_left", mirror, 1); chk("move_backward", move_state, 2); chk("x_30", x, 30);

        // Reset mid-jump
        btn_up = 1'b1;
        wait_tick();
        btn_up = 1'b0;
        repeat (2) wait_tick();
        chk("midjump_air", in_air, 1);
        rst_n = 1'b0;
        cyc();
        chk("rst_jump_y", y, 32); chk("rst_jump_air", in_air, 0); chk("rst_jump_x", x, 24);
        rst_n = 1'b1;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
